// File: rtl/ice40_himax_frame_capture.sv
// ice40_himax_frame_capture
// Camera-side capture stage for the ML sequencer. Samples 8-bit mono Himax
// pixels, crops them to an H_ACTIVE x V_ACTIVE window, and keeps only pixels
// whose x and y both have their low SUB_LOG2 bits clear. The kept pixels are
// written row-major into the ML frame buffer. After the frame is written,
// o_vid_rdy is raised. The buffer is then protected from overwrite until the
// ML engine has run, which it signals by taking i_ml_rdy low and then high.
//
// Ports:
//   clk          capture clock (camera pclk domain)
//   resetn       synchronous active-low reset
//   i_cam_vsync  frame valid
//   i_cam_hsync  line valid; a pixel is valid when vsync & hsync
//   i_cam_data   pixel byte
//   i_arm        capture enable, only acts at a frame start
//   i_ml_rdy     1 = ML engine idle/done, 0 = ML running
//   o_we         buffer write strobe
//   o_waddr      buffer write address (linear, row-major)
//   o_wdata      buffer write data
//   o_vid_rdy    frame complete in buffer, waiting for ML start
//   o_busy       state machine not idle
//   o_frame_cnt  accepted frame count, wraps at 255
//   o_err        1-clk pulse when a frame is rejected (only with HIMAX_CAP_CHECK_EN)
//
// Build option HIMAX_CAP_CHECK_EN enables the frame integrity check. When it
// is on, a frame is rejected if any line length differs from H_ACTIVE or if
// the line count differs from V_ACTIVE.

module ice40_himax_frame_capture #(
  parameter int unsigned H_ACTIVE = 324,
  parameter int unsigned V_ACTIVE = 324,
  parameter int unsigned SUB_LOG2 = 1,
  parameter int unsigned AW       = 15
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_cam_vsync,
  input  logic          i_cam_hsync,
  input  logic [7:0]    i_cam_data,
  input  logic          i_arm,
  input  logic          i_ml_rdy,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [7:0]    o_wdata,
  output logic          o_vid_rdy,
  output logic          o_busy,
  output logic [7:0]    o_frame_cnt,
  output logic          o_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_VS = 3'd1,
    S_CAP     = 3'd2,
    S_READY   = 3'd3,
    S_ML      = 3'd4
  } state_t;

  localparam logic [9:0] H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM    = 10'(V_ACTIVE);
  localparam logic [9:0] SUB_MASK = 10'((1 << SUB_LOG2) - 1);

  state_t          r_state;
  state_t          w_state_next;

  logic            r_vs_q, r_vs_q2, r_hs_q, r_hs_q2;
  logic [7:0]      r_d_q;
  logic [9:0]      r_x, r_y;
  logic [AW-1:0]   r_addr;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [7:0]      r_wdata;
  logic [7:0]      r_frame_cnt;

  logic            w_vs_rise, w_vs_fall, w_hs_fall, w_pix, w_keep;
  logic [9:0]      w_x_inc, w_y_inc;
  logic            w_frame_bad;

  assign w_vs_rise = r_vs_q & ~r_vs_q2;
  assign w_vs_fall = ~r_vs_q & r_vs_q2;
  assign w_hs_fall = ~r_hs_q & r_hs_q2;
  assign w_pix     = r_vs_q & r_hs_q;

  assign w_x_inc = (r_x == '1) ? r_x : r_x + 10'd1;
  assign w_y_inc = (r_y == '1) ? r_y : r_y + 10'd1;

  assign w_keep = w_pix && (r_x < H_LIM) && (r_y < V_LIM) &&
                  ((r_x & SUB_MASK) == '0) && ((r_y & SUB_MASK) == '0);

`ifdef HIMAX_CAP_CHECK_EN
  logic       r_bad;
  logic       r_err;
  logic [9:0] w_y_final;

  // A line end can coincide with the frame end, so fold that line into both
  // the length check and the final line count.
  assign w_y_final   = w_hs_fall ? w_y_inc : r_y;
  assign w_frame_bad = r_bad | (w_hs_fall && (r_x != H_LIM)) | (w_y_final != V_LIM);
  assign o_err       = r_err;
`else
  assign w_frame_bad = 1'b0;
  assign o_err       = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (i_arm)      w_state_next = S_WAIT_VS;
      S_WAIT_VS: if (w_vs_rise)  w_state_next = S_CAP;
      S_CAP:     if (w_vs_fall)  w_state_next = w_frame_bad ? S_WAIT_VS : S_READY;
      S_READY:   if (!i_ml_rdy)  w_state_next = S_ML;
      S_ML:      if (i_ml_rdy)   w_state_next = i_arm ? S_WAIT_VS : S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      // The vsync history starts high so that a frame already in progress
      // when reset is released cannot look like a rising edge.
      r_vs_q      <= 1'b1;
      r_vs_q2     <= 1'b1;
      r_hs_q      <= 1'b0;
      r_hs_q2     <= 1'b0;
      r_d_q       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_frame_cnt <= '0;
`ifdef HIMAX_CAP_CHECK_EN
      r_bad       <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_vs_q  <= i_cam_vsync;
      r_vs_q2 <= r_vs_q;
      r_hs_q  <= i_cam_hsync;
      r_hs_q2 <= r_hs_q;
      r_d_q   <= i_cam_data;
      r_we    <= 1'b0;
`ifdef HIMAX_CAP_CHECK_EN
      r_err   <= (r_state == S_CAP) && w_vs_fall && w_frame_bad;
`endif
      case (r_state)
        S_WAIT_VS: begin
          if (w_vs_rise) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
`ifdef HIMAX_CAP_CHECK_EN
            r_bad  <= 1'b0;
`endif
          end
        end
        S_CAP: begin
          if (w_pix) begin
            r_x <= w_x_inc;
            if (w_keep) begin
              r_we    <= 1'b1;
              r_waddr <= r_addr;
              r_wdata <= r_d_q;
              r_addr  <= r_addr + AW'(1);
            end
          end
          if (w_hs_fall) begin
            r_x <= '0;
            r_y <= w_y_inc;
`ifdef HIMAX_CAP_CHECK_EN
            if (r_x != H_LIM) r_bad <= 1'b1;
`endif
          end
          if (w_vs_fall && !w_frame_bad) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_we        = r_we;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_frame_cnt = r_frame_cnt;
  assign o_vid_rdy   = (r_state == S_READY);
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ice40_himax_frame_capture.sv
// Randomized self-checking bench for ice40_himax_frame_capture. It uses a
// reduced window so that every scenario fits in a short run. A frame-level
// model computes which pixels must reach the buffer, in which order, and at
// which address. A monitor compares each write strobe against that queue.

module tb_ice40_himax_frame_capture;

  localparam int H   = 16;
  localparam int V   = 12;
  localparam int SUB = 1;
  localparam int AW  = 8;
`ifdef HIMAX_CAP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk;
  logic          resetn;
  logic          i_cam_vsync, i_cam_hsync;
  logic [7:0]    i_cam_data;
  logic          i_arm, i_ml_rdy;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [7:0]    o_wdata;
  logic          o_vid_rdy, o_busy, o_err;
  logic [7:0]    o_frame_cnt;

  ice40_himax_frame_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SUB_LOG2(SUB), .AW(AW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .i_cam_vsync(i_cam_vsync), .i_cam_hsync(i_cam_hsync), .i_cam_data(i_cam_data),
    .i_arm(i_arm), .i_ml_rdy(i_ml_rdy),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_vid_rdy(o_vid_rdy), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_fcnt = 0;
  int  err_cycles = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (o_err === 1'b1) err_cycles++;
    if (o_we === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_we", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("waddr", int'(o_waddr), e.addr);
        check("wdata", int'(o_wdata), e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_we"},   int'(o_we), 0);
    check({tag, "_addr"}, int'(o_waddr), 0);
    check({tag, "_rdy"},  int'(o_vid_rdy), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_fcnt"}, int'(o_frame_cnt), 0);
    check({tag, "_err"},  int'(o_err), 0);
  endtask

  // Drives one frame of nl lines, each ll pixels long, with random data.
  // When cap is set, the model queues the pixels that the capture rules keep.
  // arm_line raises i_arm at that line. rst_line pulses resetn at that line;
  // nothing that follows in the same frame may reach the buffer.
  task automatic send_frame(input int nl, input int ll, input bit cap,
                            input int arm_line, input int rst_line);
    int  idx;
    bit  on;
    wr_t w;
    idx = 0;
    on  = cap;
    tick(1);
    i_cam_vsync = 1'b1;
    i_cam_hsync = 1'b0;
    tick($urandom_range(3, 6));
    for (int y = 0; y < nl; y++) begin
      if (y == arm_line) i_arm = 1'b1;
      if (y == rst_line) begin
        resetn = 1'b0;
        tick(1);
        @(negedge clk);
        check_reset_outs("midrst");
        tick(2);
        resetn = 1'b1;
        on = 1'b0;
        exp_fcnt = 0;
      end
      for (int x = 0; x < ll; x++) begin
        i_cam_hsync = 1'b1;
        i_cam_data  = 8'($urandom);
        if (on && x < H && y < V && (x % (1 << SUB)) == 0 && (y % (1 << SUB)) == 0) begin
          w.addr = idx;
          w.data = int'(i_cam_data);
          exp_q.push_back(w);
          idx++;
        end
        tick(1);
      end
      i_cam_hsync = 1'b0;
      i_cam_data  = 8'($urandom);
      tick($urandom_range(3, 5));
    end
    i_cam_vsync = 1'b0;
  endtask

  // Call right after send_frame has dropped vsync on a frame the DUT captured.
  task automatic end_frame(input bit good);
    int err0;
    err0 = err_cycles;
    sample_next();
    check("vid_rdy_early", int'(o_vid_rdy), 0);
    @(negedge clk);
    @(negedge clk);
    check("vid_rdy", int'(o_vid_rdy), int'(good));
    if (good) exp_fcnt = (exp_fcnt + 1) % 256;
    @(negedge clk);
    @(negedge clk);
    check("frame_cnt", int'(o_frame_cnt), exp_fcnt);
    check("missing_we", exp_q.size(), 0);
    check("err_pulses", err_cycles - err0, (CHK && !good) ? 1 : 0);
    check("busy_after_frame", int'(o_busy), 1);
  endtask

  task automatic ml_cycle(input bit arm_after);
    tick(2);
    i_ml_rdy = 1'b0;
    sample_next();
    check("vid_rdy_drop", int'(o_vid_rdy), 0);
    check("busy_ml", int'(o_busy), 1);
    tick(3);
    i_arm    = arm_after;
    i_ml_rdy = 1'b1;
    sample_next();
    check("busy_after_ml", int'(o_busy), int'(arm_after));
  endtask

  function automatic bit frame_good(input int nl, input int ll);
    return !CHK || (nl == V && ll == H);
  endfunction

  initial begin
    int nl, ll;
    resetn = 1'b0; i_arm = 1'b0; i_ml_rdy = 1'b1;
    i_cam_vsync = 1'b0; i_cam_hsync = 1'b0; i_cam_data = '0;

    // Reset held with sensor lines toggling.
    for (int i = 0; i < 4; i++) begin
      i_cam_vsync = 1'($urandom);
      i_cam_hsync = 1'($urandom);
      i_cam_data  = 8'($urandom);
      tick(1);
      @(negedge clk);
      check_reset_outs("reset");
    end
    i_cam_vsync = 1'b0; i_cam_hsync = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(2);
    check("idle_busy", int'(o_busy), 0);
    i_arm = 1'b1;
    tick(2);
    check("armed_busy", int'(o_busy), 1);

    // Nominal full-window frame.
    send_frame(V, H, 1'b1, -1, -1);
    end_frame(1'b1);

    // A frame arriving while the buffer is held must not write.
    send_frame(V, H, 1'b0, -1, -1);
    tick(6);
    check("vid_rdy_hold", int'(o_vid_rdy), 1);
    check("fcnt_hold", int'(o_frame_cnt), exp_fcnt);
    ml_cycle(1'b1);
    send_frame(V, H, 1'b1, -1, -1);
    end_frame(1'b1);

    // Late arm: arming partway through a frame must wait for the next frame.
    ml_cycle(1'b0);
    check("idle_after_ml", int'(o_busy), 0);
    send_frame(V, H, 1'b0, 5, -1);
    tick(6);
    check("late_arm_rdy", int'(o_vid_rdy), 0);
    check("late_arm_busy", int'(o_busy), 1);
    send_frame(V, H, 1'b1, -1, -1);
    end_frame(1'b1);
    ml_cycle(1'b1);

    // Short frame, then a frame that overruns the window in both directions.
    send_frame(V - 2, H, 1'b1, -1, -1);
    end_frame(frame_good(V - 2, H));
    if (frame_good(V - 2, H)) ml_cycle(1'b1);
    send_frame(V + 3, H + 4, 1'b1, -1, -1);
    end_frame(frame_good(V + 3, H + 4));
    if (frame_good(V + 3, H + 4)) ml_cycle(1'b1);

    // Random frame geometries.
    for (int k = 0; k < 3; k++) begin
      nl = $urandom_range(V - 2, V + 2);
      ll = $urandom_range(H - 1, H + 2);
      send_frame(nl, ll, 1'b1, -1, -1);
      end_frame(frame_good(nl, ll));
      if (frame_good(nl, ll)) ml_cycle(1'b1);
    end

    // Reset partway through a frame, with arm still high.
    send_frame(V, H, 1'b1, -1, 3);
    tick(6);
    check("postrst_rdy", int'(o_vid_rdy), 0);
    check("postrst_fcnt", int'(o_frame_cnt), 0);
    check("postrst_busy", int'(o_busy), 1);
    check("postrst_missing", exp_q.size(), 0);
    send_frame(V, H, 1'b1, -1, -1);
    end_frame(1'b1);

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
